// File: rtl/error_countdown_timer_pkg.sv
// Shared constants, types and helpers for the error countdown timer.
// Holds the countdown-length limits, error codes, the system clock rate
// (also used by the debounce logic), the FSM state type, and two helpers:
// countdown-length selection and binary-to-BCD conversion for 0..19.
package error_countdown_timer_pkg;

    localparam int unsigned CLK_FREQ_HZ_DEFAULT   = 100_000_000;

    localparam int unsigned MIN_ERROR_SECONDS     = 5;
    localparam int unsigned MAX_ERROR_SECONDS     = 19;
    localparam int unsigned DEFAULT_ERROR_SECONDS = 10;

    localparam logic [3:0] ERR_NONE  = 4'h0;
    localparam logic [3:0] ERR_INPUT = 4'h1;
    localparam logic [3:0] ERR_GEN   = 4'h2;
    localparam logic [3:0] ERR_CALC  = 4'h3;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StCount  = 2'd1,
        StExpire = 2'd2
    } timer_state_e;

    // Configured length if it lies in [min_s, max_s], otherwise the default.
    function automatic logic [4:0] sel_len(input logic [4:0]  cfg,
                                           input int unsigned min_s,
                                           input int unsigned max_s,
                                           input int unsigned def_s);
        if ((32'(cfg) >= min_s) && (32'(cfg) <= max_s)) begin
            return cfg;
        end
        return 5'(def_s);
    endfunction

    // {tens, ones} BCD digits for values 0..19.
    function automatic logic [7:0] to_bcd(input logic [4:0] secs);
        logic [3:0] tens;
        logic [4:0] ones;
        tens = (secs >= 5'd10) ? 4'd1 : 4'd0;
        ones = (secs >= 5'd10) ? (secs - 5'd10) : secs;
        return {tens, 4'(ones)};
    endfunction

endpackage

// File: rtl/error_countdown_timer_if.sv
// Bus between a mode block (master) and the error countdown timer (slave).
//   config_error_seconds  configured countdown length
//   err_start / err_code_in  start/restart pulse and the code sampled with it
//   err_clear             abort pulse
//   busy, seconds_left, sec_tens, sec_ones, blink, err_code_latched,
//   timeout_pulse         timer status back to the mode block / display
interface error_countdown_timer_if;

    logic [4:0] config_error_seconds;
    logic       err_start;
    logic [3:0] err_code_in;
    logic       err_clear;

    logic       busy;
    logic [4:0] seconds_left;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       blink;
    logic [3:0] err_code_latched;
    logic       timeout_pulse;

    modport master (
        output config_error_seconds,
        output err_start,
        output err_code_in,
        output err_clear,
        input  busy,
        input  seconds_left,
        input  sec_tens,
        input  sec_ones,
        input  blink,
        input  err_code_latched,
        input  timeout_pulse
    );

    modport slave (
        input  config_error_seconds,
        input  err_start,
        input  err_code_in,
        input  err_clear,
        output busy,
        output seconds_left,
        output sec_tens,
        output sec_ones,
        output blink,
        output err_code_latched,
        output timeout_pulse
    );

endinterface

// File: rtl/error_countdown_timer_clk_tick_gen.sv
// Prescaler producing half-second and one-second pulses.
//   clk, rst_n    clock, asynchronous active-low reset
//   i_enable      count only while high; the counter holds otherwise
//   i_sync_clr    synchronous clear to 0 (wins over i_enable)
//   o_half_tick   one-cycle pulse at count CLK_FREQ_HZ/2-1
//   o_sec_tick    one-cycle pulse at count CLK_FREQ_HZ-1, where the counter wraps
module error_countdown_timer_clk_tick_gen #(
    parameter int unsigned CLK_FREQ_HZ = 100_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_enable,
    input  logic i_sync_clr,
    output logic o_half_tick,
    output logic o_sec_tick
);

    localparam int unsigned CntW = (CLK_FREQ_HZ > 2) ? $clog2(CLK_FREQ_HZ) : 1;
    localparam logic [CntW-1:0] HalfLast = CntW'(CLK_FREQ_HZ / 2 - 1);
    localparam logic [CntW-1:0] SecLast  = CntW'(CLK_FREQ_HZ - 1);

    logic [CntW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_sync_clr) begin
            r_cnt <= '0;
        end else if (i_enable) begin
            if (r_cnt == SecLast) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CntW'(1);
            end
        end
    end

    assign o_half_tick = i_enable && (r_cnt == HalfLast);
    assign o_sec_tick  = i_enable && (r_cnt == SecLast);

endmodule

// File: rtl/error_countdown_timer.sv
// User-visible error countdown.
//   clk, rst_n   clock, asynchronous active-low reset
//   io_bus       slave side of error_countdown_timer_if: start/clear pulses,
//                error code and configured length in; remaining seconds
//                (binary + BCD), blink, latched code and timeout pulse out
// err_start loads the (range-checked) length and counts down once per second;
// reaching zero emits a one-cycle timeout_pulse. err_clear aborts silently.
module error_countdown_timer
    import error_countdown_timer_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = CLK_FREQ_HZ_DEFAULT,
    parameter int unsigned MIN_SECONDS = MIN_ERROR_SECONDS,
    parameter int unsigned MAX_SECONDS = MAX_ERROR_SECONDS,
    parameter int unsigned DEF_SECONDS = DEFAULT_ERROR_SECONDS
) (
    input logic                   clk,
    input logic                   rst_n,
    error_countdown_timer_if.slave io_bus
);

    timer_state_e r_state;
    logic         r_busy;
    logic [4:0]   r_seconds;
    logic         r_blink;
    logic [3:0]   r_code;
    logic         r_timeout;

    logic         w_half_tick;
    logic         w_sec_tick;
    logic         w_tick_clr;
    logic         w_enable;
    logic [4:0]   w_len;
    logic [7:0]   w_bcd;

    // Restarting or aborting always realigns the prescaler to a whole second.
    assign w_tick_clr = io_bus.err_start | io_bus.err_clear;
    assign w_enable   = (r_state == StCount);
    assign w_len      = sel_len(io_bus.config_error_seconds, MIN_SECONDS, MAX_SECONDS,
                                DEF_SECONDS);

    error_countdown_timer_clk_tick_gen #(
        .CLK_FREQ_HZ(CLK_FREQ_HZ)
    ) u_tick_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_enable   (w_enable),
        .i_sync_clr (w_tick_clr),
        .o_half_tick(w_half_tick),
        .o_sec_tick (w_sec_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= StIdle;
            r_busy    <= 1'b0;
            r_seconds <= '0;
            r_blink   <= 1'b0;
            r_code    <= ERR_NONE;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            // Priority: clear > start > tick.
            if (io_bus.err_clear) begin
                r_state   <= StIdle;
                r_busy    <= 1'b0;
                r_seconds <= '0;
                r_blink   <= 1'b0;
                r_code    <= ERR_NONE;
            end else if (io_bus.err_start) begin
                r_state   <= StCount;
                r_busy    <= 1'b1;
                r_seconds <= w_len;
                r_blink   <= 1'b0;
                r_code    <= io_bus.err_code_in;
            end else begin
                unique case (r_state)
                    StIdle: begin
                        r_state <= StIdle;
                    end
                    StCount: begin
                        if (w_sec_tick) begin
                            if (r_seconds <= 5'd1) begin
                                r_state   <= StExpire;
                                r_busy    <= 1'b0;
                                r_seconds <= '0;
                                r_blink   <= 1'b0;
                                r_timeout <= 1'b1;
                            end else begin
                                r_seconds <= r_seconds - 5'd1;
                                r_blink   <= ~r_blink;
                            end
                        end else if (w_half_tick) begin
                            r_blink <= ~r_blink;
                        end
                    end
                    StExpire: begin
                        r_state <= StIdle;
                    end
                    default: begin
                        r_state <= StIdle;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign w_bcd = to_bcd(r_seconds);

    assign io_bus.busy             = r_busy;
    assign io_bus.seconds_left     = r_seconds;
    assign io_bus.sec_tens         = w_bcd[7:4];
    assign io_bus.sec_ones         = w_bcd[3:0];
    assign io_bus.blink            = r_blink;
    assign io_bus.err_code_latched = r_code;
    assign io_bus.timeout_pulse    = r_timeout;

endmodule

// File: tb/tb_error_countdown_timer.sv
// Bench for error_countdown_timer at CLK_FREQ_HZ=10: directed scenarios
// followed by random start/clear traffic, all checked against a model that
// tracks elapsed cycles since the last start.
module tb_error_countdown_timer;
    import error_countdown_timer_pkg::*;

    localparam int unsigned FREQ = 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    error_countdown_timer_if bus_if ();

    error_countdown_timer #(
        .CLK_FREQ_HZ(FREQ)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io_bus(bus_if)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Model: countdown described by length and cycles elapsed since start.
    bit         m_active;
    int         m_elapsed;
    int         m_len;
    logic [3:0] m_code;
    bit         m_timeout;

    int dut_pulses     = 0;
    int last_pulse_cyc = -1;

    always @(negedge clk) begin
        if (bus_if.timeout_pulse === 1'b1) begin
            dut_pulses++;
            last_pulse_cyc = cyc;
        end
    end

    function automatic int exp_len(input int cfg);
        if (cfg >= int'(MIN_ERROR_SECONDS) && cfg <= int'(MAX_ERROR_SECONDS)) return cfg;
        return int'(DEFAULT_ERROR_SECONDS);
    endfunction

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
            $error("check %s did not hold", tag);
        end
    endtask

    task automatic model_reset();
        m_active  = 1'b0;
        m_elapsed = 0;
        m_len     = 0;
        m_code    = ERR_NONE;
        m_timeout = 1'b0;
    endtask

    task automatic model_edge();
        if (!rst_n) begin
            model_reset();
        end else begin
            m_timeout = 1'b0;
            if (bus_if.err_clear) begin
                m_active = 1'b0;
                m_code   = ERR_NONE;
            end else if (bus_if.err_start) begin
                m_active  = 1'b1;
                m_elapsed = 0;
                m_len     = exp_len(int'(bus_if.config_error_seconds));
                m_code    = bus_if.err_code_in;
            end else if (m_active) begin
                m_elapsed++;
                if (m_elapsed == int'(FREQ) * m_len) begin
                    m_active  = 1'b0;
                    m_timeout = 1'b1;
                end
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        int secs;
        int blk;
        secs = m_active ? (m_len - m_elapsed / int'(FREQ)) : 0;
        blk  = m_active ? ((m_elapsed / int'(FREQ / 2)) % 2) : 0;
        cmp({tag, ":busy"},    32'(bus_if.busy),             32'(m_active));
        cmp({tag, ":secs"},    32'(bus_if.seconds_left),     32'(secs));
        cmp({tag, ":tens"},    32'(bus_if.sec_tens),         32'(secs / 10));
        cmp({tag, ":ones"},    32'(bus_if.sec_ones),         32'(secs % 10));
        cmp({tag, ":blink"},   32'(bus_if.blink),            32'(blk));
        cmp({tag, ":code"},    32'(bus_if.err_code_latched), 32'(m_code));
        cmp({tag, ":timeout"}, 32'(bus_if.timeout_pulse),    32'(m_timeout));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
        check_outputs(tag);
    endtask

    task automatic steps(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    task automatic start(input string tag, input int cfg, input int code);
        bus_if.config_error_seconds = 5'(cfg);
        bus_if.err_code_in          = 4'(code);
        bus_if.err_start            = 1'b1;
        step(tag);
        bus_if.err_start            = 1'b0;
    endtask

    task automatic clear(input string tag);
        bus_if.err_clear = 1'b1;
        step(tag);
        bus_if.err_clear = 1'b0;
    endtask

    initial begin
        int s;
        int p0;
        bus_if.config_error_seconds = 5'd0;
        bus_if.err_start            = 1'b0;
        bus_if.err_code_in          = 4'd0;
        bus_if.err_clear            = 1'b0;
        model_reset();

        // Asynchronous reset with no clock edge yet.
        #1 rst_n = 1'b0;
        #1 check_outputs("reset");
        steps("reset_hold", 2);
        rst_n = 1'b1;
        steps("idle", 3);

        // Basic 5 s countdown, code 3.
        p0 = dut_pulses;
        start("cfg5", 5, 3);
        s = cyc;
        steps("cfg5_run", 60);
        cmp("cfg5_pulse_count", 32'(dut_pulses - p0), 32'd1);
        cmp("cfg5_pulse_delay", 32'(last_pulse_cyc - s), 32'd50);

        // Out-of-range lengths fall back to the default; 15 exercises BCD tens.
        start("cfg3", 3, 1);
        steps("cfg3_run", int'(DEFAULT_ERROR_SECONDS) * int'(FREQ) + 3);
        start("cfg20", 20, 2);
        steps("cfg20_run", int'(DEFAULT_ERROR_SECONDS) * int'(FREQ) + 3);
        start("cfg15", 15, 7);
        cmp("cfg15_tens0", 32'(bus_if.sec_tens), 32'd1);
        cmp("cfg15_ones0", 32'(bus_if.sec_ones), 32'd5);
        steps("cfg15_run", 10);
        cmp("cfg15_tens1", 32'(bus_if.sec_tens), 32'd1);
        cmp("cfg15_ones1", 32'(bus_if.sec_ones), 32'd4);
        clear("cfg15_clr");

        // Restart at cycle 25 of a 5 s count.
        p0 = dut_pulses;
        start("rst25_a", 5, 4);
        steps("rst25_run", 24);
        start("rst25_b", 5, 6);
        s = cyc;
        steps("rst25_run2", 55);
        cmp("rst25_pulse_count", 32'(dut_pulses - p0), 32'd1);
        cmp("rst25_pulse_delay", 32'(last_pulse_cyc - s), 32'd50);

        // Clear at cycle 17: no timeout ever.
        p0 = dut_pulses;
        start("clr17", 5, 9);
        steps("clr17_run", 16);
        clear("clr17_clr");
        steps("clr17_after", 60);
        cmp("clr17_no_pulse", 32'(dut_pulses - p0), 32'd0);

        // Clear and start together from IDLE: clear wins.
        bus_if.err_clear = 1'b1;
        start("clr_and_start", 5, 5);
        bus_if.err_clear = 1'b0;
        steps("clr_and_start_after", 5);

        // Config change mid-count has no effect.
        start("cfgchg", 6, 8);
        steps("cfgchg_run", 12);
        bus_if.config_error_seconds = 5'd19;
        steps("cfgchg_run2", 55);

        // Reset at cycle 33 of a count: outputs drop immediately, no pulse later.
        p0 = dut_pulses;
        start("arst", 5, 10);
        steps("arst_run", 32);
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_outputs("arst_async");
        steps("arst_hold", 2);
        rst_n = 1'b1;
        steps("arst_after", 60);
        cmp("arst_no_pulse", 32'(dut_pulses - p0), 32'd0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            bus_if.config_error_seconds = 5'($urandom_range(0, 31));
            bus_if.err_code_in          = 4'($urandom_range(0, 15));
            bus_if.err_start            = ($urandom_range(0, 39) == 0);
            bus_if.err_clear            = ($urandom_range(0, 149) == 0);
            step("rand");
        end
        bus_if.err_start = 1'b0;
        bus_if.err_clear = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
